crc_frame_tx: RTL and testbench

Frame-level CRC appender for the transmit path. It accepts a stream of data words with an end-of-frame marker, computes the CRC bit-serially (MSB first) over every word of the frame, and forwards the words unchanged downstream. After the last word it appends one extra word carrying the finished CRC. It sits between the frame source and the line serializer, and uses the same normal-form polynomial convention as the standalone CRC generator.

---
 rtl/crc_frame_pkg.sv | 33 +++
 rtl/crc_frame_tx_if.sv | 21 ++
 rtl/crc_serial_core.sv | 46 ++++
 rtl/crc_frame_tx.sv | 131 +++++++++++++
 tb/tb_crc_frame_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_pkg.sv
// ============================================================================
// crc_frame_pkg : shared FSM state type and single-bit CRC update function
// Revision: 1.0
// ============================================================================
`default_nettype none

package crc_frame_pkg;

  localparam int MAX_PW   = 32;
  localparam int MSB_W    = $clog2(MAX_PW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DATA = 2'd2,
    CRC  = 2'd3
  } state_e;

  // Operands are carried at MAX_PW; msb selects the live top bit of the register.
  function automatic logic [MAX_PW-1:0] crc_step(
    input logic [MAX_PW-1:0] crc,
    input logic              bit_in,
    input logic [MAX_PW-1:0] poly,
    input logic [MSB_W-1:0]  msb
  );
    logic fb;
    fb = crc[msb] ^ bit_in;
    return (crc << 1) ^ (fb ? poly : '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_frame_tx_if.sv
// ============================================================================
// crc_frame_tx_if : valid/ready word stream with end-of-frame marker
// Revision: 1.0
// ============================================================================
`default_nettype none

interface crc_frame_tx_if #(
  parameter int DW = 8
) ();

  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          ready;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);

endinterface

`default_nettype wire

// File: rtl/crc_serial_core.sv
// ============================================================================
// crc_serial_core : PW-bit Galois CRC register, one message bit per enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_serial_core
  import crc_frame_pkg::*;
#(
  parameter int          PW   = 8,
  parameter logic [PW-1:0] POLY = 8'h07,
  parameter logic [PW-1:0] INIT = '0
) (
  input  wire logic          clk,
  input  wire logic          rst_b,
  input  wire logic          init,
  input  wire logic          shift_en,
  input  wire logic          bit_in,
  output      logic [PW-1:0] crc_out
);

  logic [PW-1:0] crc_q;
  logic [PW-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (shift_en) begin
      crc_d = PW'(crc_step(MAX_PW'(crc_q), bit_in, MAX_PW'(POLY), MSB_W'(PW - 1)));
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

`default_nettype wire

// File: rtl/crc_frame_tx.sv
// ============================================================================
// crc_frame_tx : forwards frame words unchanged and appends a bit-serial CRC word
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_frame_tx
  import crc_frame_pkg::*;
#(
  parameter int            DW     = 8,
  parameter int            PW     = 8,
  parameter logic [PW-1:0] POLY   = 8'h07,
  parameter logic [PW-1:0] INIT   = '0,
  parameter logic [PW-1:0] XOROUT = '0
) (
  input wire logic       clk,
  input wire logic       rst_b,
  crc_frame_tx_if.slave  s,
  crc_frame_tx_if.master m
);

  localparam int CW = $clog2(DW) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]   word_q,  word_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            last_q,  last_d;

  logic            crc_init;
  logic            shift_en;
  logic [PW-1:0]   crc_val;

  logic            s_ready_w;
  logic            m_valid_w;
  logic            m_last_w;
  logic [DW-1:0]   m_data_w;

  crc_serial_core #(
    .PW   (PW),
    .POLY (POLY),
    .INIT (INIT)
  ) u_core (
    .clk      (clk),
    .rst_b    (rst_b),
    .init     (crc_init),
    .shift_en (shift_en),
    .bit_in   (shift_q[DW-1]),
    .crc_out  (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    shift_d   = shift_q;
    last_d    = last_q;
    crc_init  = 1'b0;
    shift_en  = 1'b0;
    s_ready_w = 1'b0;
    m_valid_w = 1'b0;
    m_last_w  = 1'b0;
    m_data_w  = '0;

    unique case (state_q)
      IDLE: begin
        s_ready_w = 1'b1;
        if (s.valid) begin
          word_d  = s.data;
          shift_d = s.data;
          last_d  = s.last;
          cnt_d   = CW'(DW);
          state_d = CALC;
        end
      end
      CALC: begin
        // The counter parks at 1 on the final shift so it never underflows.
        shift_en = 1'b1;
        shift_d  = shift_q << 1;
        if (cnt_q == CW'(1)) begin
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        m_valid_w = 1'b1;
        m_data_w  = word_q;
        if (m.ready) begin
          state_d = last_q ? CRC : IDLE;
        end
      end
      CRC: begin
        m_valid_w = 1'b1;
        m_last_w  = 1'b1;
        m_data_w  = DW'(crc_val ^ XOROUT);
        if (m.ready) begin
          crc_init = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

  assign s.ready = s_ready_w;
  assign m.valid = m_valid_w;
  assign m.last  = m_last_w;
  assign m.data  = m_data_w;

endmodule

`default_nettype wire

// File: tb/tb_crc_frame_tx.sv
// ============================================================================
// tb_crc_frame_tx : directed and random frames on an 8-bit and a 16-bit instance
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc_frame_tx;

  typedef logic [15:0] wq_t[$];

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  crc_frame_tx_if #(.DW(8))  a_s ();
  crc_frame_tx_if #(.DW(8))  a_m ();
  crc_frame_tx_if #(.DW(16)) b_s ();
  crc_frame_tx_if #(.DW(16)) b_m ();

  crc_frame_tx #(
    .DW(8), .PW(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00)
  ) dut_a (
    .clk(clk), .rst_b(rst_b), .s(a_s.slave), .m(a_m.master)
  );

  crc_frame_tx #(
    .DW(16), .PW(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h55)
  ) dut_b (
    .clk(clk), .rst_b(rst_b), .s(b_s.slave), .m(b_m.master)
  );

  // CRC as the remainder of (message * x^8) mod (x^8+x^2+x+1), XOROUT applied.
  function automatic logic [7:0] ref_crc(input wq_t w, input int dw, input logic [7:0] xo);
    logic [8:0] rem;
    logic       b;
    rem = '0;
    for (int i = 0; i < w.size(); i++) begin
      for (int k = dw - 1; k >= 0; k--) begin
        b   = w[i][k];
        rem = {rem[7:0], b};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    for (int k = 0; k < 8; k++) begin
      rem = {rem[7:0], 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0] ^ xo;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit b, input logic [15:0] d, input logic v, input logic l);
    if (b) begin
      b_s.data = d; b_s.valid = v; b_s.last = l;
    end else begin
      a_s.data = d[7:0]; a_s.valid = v; a_s.last = l;
    end
  endtask

  task automatic set_mready(input bit b, input logic r);
    if (b) b_m.ready = r;
    else   a_m.ready = r;
  endtask

  task automatic sample(input bit b, output logic [15:0] d, output logic v,
                        output logic l, output logic sr);
    if (b) begin
      d = b_m.data; v = b_m.valid; l = b_m.last; sr = b_s.ready;
    end else begin
      d = {8'h00, a_m.data}; v = a_m.valid; l = a_m.last; sr = a_s.ready;
    end
  endtask

  task automatic stall_handoff(input bit b, input logic [15:0] ed, input logic el, input int stall);
    logic [15:0] od;
    logic        ov, ol, osr;
    repeat (stall) begin
      @(posedge clk); #1;
      sample(b, od, ov, ol, osr);
      chk("hold_data",   od,  ed);
      chk("hold_valid",  ov,  1'b1);
      chk("hold_last",   ol,  el);
      chk("hold_sready", osr, 1'b0);
    end
    set_mready(b, 1'b1);
    @(posedge clk); #1;
    set_mready(b, 1'b0);
  endtask

  task automatic tx_word(input bit b, input logic [15:0] d, input logic l, input int stall);
    logic [15:0] od;
    logic        ov, ol, osr;
    int          n;
    sample(b, od, ov, ol, osr);
    chk("sready_idle", osr, 1'b1);
    drive(b, d, 1'b1, l);
    @(posedge clk); #1;
    drive(b, 16'h0, 1'b0, 1'b0);
    n = 0;
    sample(b, od, ov, ol, osr);
    while (!ov && n < 64) begin
      @(posedge clk); #1;
      n++;
      sample(b, od, ov, ol, osr);
    end
    chk("latency",     n,   b ? 16 : 8);
    chk("data_echo",   od,  d);
    chk("data_mlast",  ol,  1'b0);
    chk("sready_busy", osr, 1'b0);
    stall_handoff(b, d, 1'b0, stall);
  endtask

  task automatic tx_crc(input bit b, input logic [15:0] exp, input int stall);
    logic [15:0] od;
    logic        ov, ol, osr;
    sample(b, od, ov, ol, osr);
    chk("crc_valid", ov, 1'b1);
    chk("crc_data",  od, exp);
    chk("crc_last",  ol, 1'b1);
    stall_handoff(b, exp, 1'b1, stall);
    sample(b, od, ov, ol, osr);
    chk("post_valid",  ov,  1'b0);
    chk("post_sready", osr, 1'b1);
  endtask

  task automatic tx_frame(input bit b, input wq_t w, input logic [15:0] exp, input int stall);
    for (int i = 0; i < w.size(); i++) begin
      tx_word(b, w[i], (i == w.size() - 1), stall);
    end
    tx_crc(b, exp, stall);
  endtask

  task automatic chk_reset_outputs(input bit b, input string tag);
    logic [15:0] od;
    logic        ov, ol, osr;
    sample(b, od, ov, ol, osr);
    chk({tag, "_sready"}, osr, 1'b1);
    chk({tag, "_mvalid"}, ov,  1'b0);
    chk({tag, "_mlast"},  ol,  1'b0);
    chk({tag, "_mdata"},  od,  16'h0);
  endtask

  initial begin
    wq_t w;
    wq_t chkstr;
    int  len;
    int  st;

    drive(1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 1'b0, 1'b0);
    set_mready(1'b0, 1'b0);
    set_mready(1'b1, 1'b0);
    chkstr = {16'h31, 16'h32, 16'h33, 16'h34, 16'h35, 16'h36, 16'h37, 16'h38, 16'h39};

    #1;
    chk_reset_outputs(1'b0, "rst_a");
    chk_reset_outputs(1'b1, "rst_b");
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;

    // Single-word frames with known CRC-8 results.
    w = {16'h01}; tx_frame(1'b0, w, 16'h07, 0);
    w = {16'hFF}; tx_frame(1'b0, w, 16'hF3, 0);
    w = {16'h00}; tx_frame(1'b0, w, 16'h00, 0);

    // Check string twice; the second proves the register reloads between frames.
    tx_frame(1'b0, chkstr, 16'hF4, 0);
    tx_frame(1'b0, chkstr, 16'hF4, 0);

    // Back-pressure on every data word and on the CRC word.
    tx_frame(1'b0, chkstr, 16'hF4, 5);

    // Reset while word 4 of the check string is being shifted.
    for (int i = 0; i < 3; i++) tx_word(1'b0, chkstr[i], 1'b0, 0);
    drive(1'b0, chkstr[3], 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    chk_reset_outputs(1'b0, "midrst");
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    tx_frame(1'b0, chkstr, 16'hF4, 0);

    // 16-bit instance with XOROUT, padding byte included in the CRC.
    w = {16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'h3900};
    tx_frame(1'b1, w, {8'h00, ref_crc(w, 16, 8'h55)}, 1);

    // Random frames on both instances against the division model.
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 5);
      st  = $urandom_range(0, 2);
      w   = {};
      for (int i = 0; i < len; i++) w.push_back(16'($urandom_range(0, 255)));
      tx_frame(1'b0, w, {8'h00, ref_crc(w, 8, 8'h00)}, st);
    end
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 4);
      st  = $urandom_range(0, 2);
      w   = {};
      for (int i = 0; i < len; i++) w.push_back(16'($urandom_range(0, 65535)));
      tx_frame(1'b1, w, {8'h00, ref_crc(w, 16, 8'h55)}, st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
